// File: rtl/meter_ctrl.sv
// Parking-meter core: paid-time countdown, coin/reset buttons, display blink
// policy and a sequential binary-to-BCD converter for the seven-segment mux.
module meter_ctrl #(
  parameter int unsigned ADD1_SEC = 60,
  parameter int unsigned ADD2_SEC = 120,
  parameter int unsigned RST1_SEC = 15,
  parameter int unsigned RST2_SEC = 150,
  parameter int unsigned LOW_SEC  = 180,
  parameter int unsigned MAX_SEC  = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_1Hz,
  input  logic        clk_blink,
  input  logic        btn_add1,
  input  logic        btn_add2,
  input  logic        btn_rst1,
  input  logic        btn_rst2,
  output logic [13:0] time_left,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        display_en,
  output logic        expired,
  output logic [1:0]  state
);

  localparam int unsigned TW     = 14;
  localparam int unsigned SW     = TW + 1;
  localparam int unsigned BW     = 16;
  localparam int unsigned CW     = 4;
  localparam int unsigned SHIFTS = 14;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOW    = 2'd1;
  localparam logic [1:0] ST_NORMAL = 2'd2;

  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_DONE} conv_t;

  logic          hist_1hz;
  logic          tick_c;
  logic [SW-1:0] sum_c;
  logic [TW-1:0] time_next_c;
  logic          expire_next_c;
  logic [1:0]    state_next_c;
  logic          disp_next_c;
  logic          changed_c;

  conv_t         conv_state, conv_next;
  logic          load_en_c, shift_en_c, done_en_c;
  logic [CW-1:0] cnt;
  logic [BW-1:0] work;
  logic [TW-1:0] bin;
  logic [BW+TW-1:0] shifted_c;

  assign tick_c = clk_1Hz & ~hist_1hz;

  // Saturating add of one of the coin amounts.
  function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] t, input logic [SW-1:0] amt);
    logic [SW-1:0] s;
    s = SW'(t) + amt;
    return (s > SW'(MAX_SEC)) ? TW'(MAX_SEC) : s[TW-1:0];
  endfunction

  // Time update: only the highest-priority event acts; a tick under a button is dropped.
  always_comb begin
    time_next_c   = time_left;
    expire_next_c = 1'b0;
    sum_c         = '0;
    if (btn_rst2) begin
      time_next_c = TW'(RST2_SEC);
    end else if (btn_rst1) begin
      time_next_c = TW'(RST1_SEC);
    end else if (btn_add2) begin
      sum_c       = SW'(ADD2_SEC);
      time_next_c = sat_add(time_left, sum_c);
    end else if (btn_add1) begin
      sum_c       = SW'(ADD1_SEC);
      time_next_c = sat_add(time_left, sum_c);
    end else if (tick_c && (time_left != '0)) begin
      time_next_c   = time_left - TW'(1);
      expire_next_c = (time_left == TW'(1));
    end
  end

  always_comb begin
    state_next_c = ST_NORMAL;
    disp_next_c  = 1'b1;
    if (time_next_c == '0) begin
      state_next_c = ST_EMPTY;
      disp_next_c  = clk_blink;
    end else if (time_next_c < TW'(LOW_SEC)) begin
      state_next_c = ST_LOW;
      disp_next_c  = ~time_next_c[0];
    end
  end

  assign changed_c = (time_next_c != time_left);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_1hz   <= 1'b0;
      time_left  <= '0;
      expired    <= 1'b0;
      state      <= ST_EMPTY;
      display_en <= 1'b0;
    end else begin
      hist_1hz   <= clk_1Hz;
      time_left  <= time_next_c;
      expired    <= expire_next_c;
      state      <= state_next_c;
      display_en <= disp_next_c;
    end
  end

  // Converter sequencing; any change of time_left restarts from LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conv_state <= C_IDLE;
    else     conv_state <= conv_next;
  end

  always_comb begin
    conv_next  = conv_state;
    load_en_c  = 1'b0;
    shift_en_c = 1'b0;
    done_en_c  = 1'b0;
    if (changed_c) begin
      conv_next = C_LOAD;
    end else begin
      case (conv_state)
        C_IDLE:  conv_next = C_IDLE;
        C_LOAD: begin
          load_en_c = 1'b1;
          conv_next = C_SHIFT;
        end
        C_SHIFT: begin
          shift_en_c = 1'b1;
          if (cnt == CW'(SHIFTS - 1)) conv_next = C_DONE;
        end
        C_DONE: begin
          done_en_c = 1'b1;
          conv_next = C_IDLE;
        end
        default: conv_next = C_IDLE;
      endcase
    end
  end

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] w);
    logic [BW-1:0] r;
    r = w;
    for (int i = 0; i < BW / 4; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign shifted_c = {add3(work), bin} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      work      <= '0;
      bin       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      if (changed_c) bcd_valid <= 1'b0;
      if (load_en_c) begin
        bin  <= time_left;
        work <= '0;
        cnt  <= '0;
      end
      if (shift_en_c) begin
        work <= shifted_c[BW+TW-1:TW];
        bin  <= shifted_c[TW-1:0];
        cnt  <= cnt + CW'(1);
      end
      if (done_en_c) begin
        bcd       <= work;
        bcd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meter_ctrl.sv
// Bench for meter_ctrl: directed scenarios then random traffic, every cycle
// checked against an arithmetic model of the meter behaviour.
module tb_meter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_1Hz, clk_blink;
  logic        btn_add1, btn_add2, btn_rst1, btn_rst2;
  logic [13:0] time_left;
  logic [15:0] bcd;
  logic        bcd_valid, display_en, expired;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int exp_seen = 0;

  // Model state
  int m_t, m_hist, m_cyc, m_last, m_bcd, m_exp, m_disp;

  always #5 clk = ~clk;

  meter_ctrl dut (
    .clk(clk), .rst(rst), .clk_1Hz(clk_1Hz), .clk_blink(clk_blink),
    .btn_add1(btn_add1), .btn_add2(btn_add2), .btn_rst1(btn_rst1), .btn_rst2(btn_rst2),
    .time_left(time_left), .bcd(bcd), .bcd_valid(bcd_valid),
    .display_en(display_en), .expired(expired), .state(state)
  );

  function automatic int to_bcd(input int v);
    return (v / 1000) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_hist = 0; m_cyc = 0; m_last = -1000;
    m_bcd = 0; m_exp = 0; m_disp = 0;
  endtask

  task automatic check_all();
    int mstate;
    mstate = (m_t == 0) ? 0 : (m_t < 180) ? 1 : 2;
    chk("time_left", 32'(time_left), 32'(m_t));
    chk("state", 32'(state), 32'(mstate));
    chk("display_en", 32'(display_en), 32'(m_disp));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("bcd_valid", 32'(bcd_valid), 32'((m_cyc - m_last >= 16) ? 1 : 0));
    chk("bcd", 32'(bcd), 32'(m_bcd));
  endtask

  // One clock cycle with the given inputs, then model update and full check.
  task automatic step(input bit a1, input bit a2, input bit r1, input bit r2,
                      input bit hz, input bit bl);
    int old;
    bit tick;
    btn_add1 = a1; btn_add2 = a2; btn_rst1 = r1; btn_rst2 = r2;
    clk_1Hz = hz; clk_blink = bl;
    @(posedge clk);
    old  = m_t;
    tick = hz && (m_hist == 0);
    m_hist = hz;
    m_exp  = 0;
    m_cyc++;
    if (r2)      m_t = 150;
    else if (r1) m_t = 15;
    else if (a2) m_t = min2(m_t + 120, 9999);
    else if (a1) m_t = min2(m_t + 60, 9999);
    else if (tick && m_t > 0) begin
      m_t--;
      m_exp = (m_t == 0);
    end
    if (m_t != old) m_last = m_cyc;
    if (m_cyc - m_last >= 16) m_bcd = to_bcd(m_t);
    m_disp = (m_t == 0) ? int'(bl) : (m_t < 180) ? ((m_t % 2 == 0) ? 1 : 0) : 1;
    #1;
    check_all();
    if (expired === 1'b1) exp_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_tick();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    btn_add1 = 0; btn_add2 = 0; btn_rst1 = 0; btn_rst2 = 0;
    clk_1Hz = 0; clk_blink = 0;
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("rst_valid", 32'(bcd_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // No buttons: three ticks keep the meter empty, display follows blink.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1'(i % 2));
      step(0, 0, 0, 0, 1, 1'((i + 1) % 2));
      step(0, 0, 0, 0, 0, 1'(i % 2));
    end

    // Coins: 60 + 60 + 120.
    step(1, 0, 0, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0, 0);
    idle(16);
    chk("t240", 32'(time_left), 32'd240);
    chk("bcd240", 32'(bcd), 32'h0240);
    chk("valid240", 32'(bcd_valid), 32'd1);
    chk("disp240", 32'(display_en), 32'd1);

    // Reset-to-150 then ticks into the LOW blink region.
    step(0, 0, 0, 1, 0, 0);
    do_tick();
    chk("t149", 32'(time_left), 32'd149);
    chk("low149", 32'(state), 32'd1);
    chk("disp149", 32'(display_en), 32'd0);
    do_tick();
    chk("disp148", 32'(display_en), 32'd1);

    // Reset-to-15 and count down to expiry.
    step(0, 0, 1, 0, 0, 0);
    exp_seen = 0;
    for (int i = 0; i < 15; i++) do_tick();
    chk("expired_once", 32'(exp_seen), 32'd1);
    chk("empty", 32'(state), 32'd0);
    do_tick();
    chk("expired_none_at0", 32'(exp_seen), 32'd1);

    // Saturation at 9999, then a coin colliding with a tick.
    for (int i = 0; i < 167; i++) step(1, 0, 0, 0, 0, 0);
    idle(16);
    chk("t9999", 32'(time_left), 32'd9999);
    chk("bcd9999", 32'(bcd), 32'h9999);
    step(1, 0, 0, 0, 1, 0);
    chk("tick_drop_sat", 32'(time_left), 32'd9999);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("tick_drop_75", 32'(time_left), 32'd75);
    idle(2);

    // Restart of conversion mid-flight.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 0, 0);
    idle(15);
    chk("valid_wait", 32'(bcd_valid), 32'd0);
    idle(1);
    chk("bcd180", 32'(bcd), 32'h0180);
    chk("valid180", 32'(bcd_valid), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    step(1, 0, 0, 0, 0, 0);
    idle(7);
    do_reset();
    chk("rst_time", 32'(time_left), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      automatic int r = int'($urandom_range(0, 63));
      automatic bit hz = ((i / int'($urandom_range(2, 3))) % 4) < 2;
      automatic bit bl = 1'($urandom_range(0, 1));
      step(r == 0, r == 1, r == 2, r == 3, hz, bl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
